// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RISC-V definitions: datapath width, write-back
//                result-select encodings and load funct3 encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   localparam int XLEN = 32;

   // Write-back result select
   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10,
      RES_RSVD = 2'b11
   } result_src_e;

   // Load size / sign encodings (funct3)
   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } load_funct3_e;

endpackage
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : load_formatter
//  Description : Combinational load-data aligner. Picks the byte/half lane
//                addressed by addr_lo and sign- or zero-extends it.
//  Ports       : data    in  XLEN  raw word returned by memory
//                funct3  in  3     load size/sign
//                addr_lo in  2     load address bits [1:0]
//                result  out XLEN  formatted load value
//  Revision    : 1.0 - initial release
// ============================================================================
module load_formatter
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] data,
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   output logic [XLEN-1:0] result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = data[{addr_lo, 3'b000} +: 8];
   // Halfword lane depends only on addr_lo[1]; a misaligned bit 0 is ignored.
   assign w_half = addr_lo[1] ? data[31:16] : data[15:0];

   always_comb begin
      result = data;
      case (funct3)
         F3_LB:   result = {{24{w_byte[7]}}, w_byte};
         F3_LH:   result = {{16{w_half[15]}}, w_half};
         F3_LW:   result = data;
         F3_LBU:  result = {24'd0, w_byte};
         F3_LHU:  result = {16'd0, w_half};
         default: result = data;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_stage
//  Description : Pipeline write-back register. Captures the MEM-stage
//                instruction, selects/formats its result, drives the
//                register-file write port, counts retired instructions and
//                optionally offers a same-cycle bypass to decode.
//  Config      : `define WB_BYPASS_EN enables the bypass outputs; otherwise
//                fwd*_hit/fwd*_data are tied to 0 (ports still present).
//  Ports       : clk, rst (sync, active high), stall, flush
//                in_*      MEM-stage instruction fields and result candidates
//                A3/WD3/WE3 register-file write port
//                rs1/rs2 -> fwd*_hit/fwd*_data  decode bypass
//                retire_cnt  retired-instruction counter (CNT_W bits, wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
   import riscv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             in_reg_write,
   input  logic [4:0]       in_rd,
   input  logic [1:0]       in_result_src,
   input  logic [XLEN-1:0]  in_alu_result,
   input  logic [XLEN-1:0]  in_load_data,
   input  logic [XLEN-1:0]  in_pc_plus4,
   input  logic [2:0]       in_funct3,
   input  logic [1:0]       in_addr_lo,
   output logic [4:0]       A3,
   output logic [XLEN-1:0]  WD3,
   output logic             WE3,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   output logic             fwd1_hit,
   output logic             fwd2_hit,
   output logic [XLEN-1:0]  fwd1_data,
   output logic [XLEN-1:0]  fwd2_data,
   output logic [CNT_W-1:0] retire_cnt
);

   logic             r_valid;
   logic             r_reg_write;
   logic [4:0]       r_rd;
   logic [XLEN-1:0]  r_wd;
   logic [CNT_W-1:0] r_cnt;

   logic [XLEN-1:0]  w_load_fmt;
   logic [XLEN-1:0]  w_result;
   logic             w_writes_rd;

   load_formatter u_load_formatter (
      .data    (in_load_data),
      .funct3  (in_funct3),
      .addr_lo (in_addr_lo),
      .result  (w_load_fmt)
   );

   // Result is chosen before the register so WD3 is ready one cycle later.
   always_comb begin
      w_result = '0;
      case (in_result_src)
         RES_ALU:  w_result = in_alu_result;
         RES_LOAD: w_result = w_load_fmt;
         RES_PC4:  w_result = in_pc_plus4;
         default:  w_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_rd        <= 5'd0;
         r_wd        <= '0;
         r_cnt       <= '0;
      end else begin
         // The held instruction retires this cycle even if flush kills the
         // slot afterwards; only a stall delays retirement.
         if (r_valid && !stall)
            r_cnt <= r_cnt + CNT_W'(1);
         if (flush) begin
            r_valid <= 1'b0;
         end else if (!stall) begin
            r_valid <= in_valid;
            if (in_valid) begin
               r_reg_write <= in_reg_write;
               r_rd        <= in_rd;
               r_wd        <= w_result;
            end
         end
      end
   end

   assign w_writes_rd = r_valid && r_reg_write && (r_rd != 5'd0);

   assign A3         = r_rd;
   assign WD3        = r_wd;
   assign WE3        = w_writes_rd && !stall;
   assign retire_cnt = r_cnt;

`ifdef WB_BYPASS_EN
   // Bypass ignores stall: decode must see the pending value whenever the
   // stage holds a live write, stalled or not.
   assign fwd1_hit  = w_writes_rd && (r_rd == rs1);
   assign fwd2_hit  = w_writes_rd && (r_rd == rs2);
   assign fwd1_data = fwd1_hit ? r_wd : '0;
   assign fwd2_data = fwd2_hit ? r_wd : '0;
`else
   logic w_unused_rs;
   assign w_unused_rs = ^{rs1, rs2};
   assign fwd1_hit    = 1'b0;
   assign fwd2_hit    = 1'b0;
   assign fwd1_data   = '0;
   assign fwd2_data   = '0;
`endif

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter CNT_W, default 32: width of the retire counter.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  hold stage contents; no capture, no retire.
REQ-005 flush  in  1  kill the held instruction at the next edge.
REQ-006 in_valid  in  1  upstream (MEM) instruction present.
REQ-007 in_reg_write  in  1  instruction writes rd.
REQ-008 in_rd  in  5  destination register index.
REQ-009 in_result_src  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-010 in_alu_result, in_load_data, in_pc_plus4  in  32 each  result candidates.
REQ-011 in_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 in_addr_lo  in  2  load address bits [1:0].
REQ-013 A3  out  5  register-file write index.
REQ-014 WD3  out  32  register-file write data.
REQ-015 WE3  out  1  register-file write enable.
REQ-016 rs1, rs2  in  5 each  decode-stage read indices.
REQ-017 fwd1_hit, fwd2_hit  out  1 each  bypass valid for rs1 or rs2.
REQ-018 fwd1_data, fwd2_data  out  32 each  bypass data.
REQ-019 retire_cnt  out  CNT_W  count of retired instructions.

Function
REQ-020 Capture occurs when in_valid=1 and stall=0: valid_q<=1, rd/reg_write/formatted result registered; in_valid=0 with stall=0 sets valid_q<=0.
REQ-021 The result is selected and formatted at capture, giving one-cycle latency from input to A3/WD3.
REQ-022 Load formatting selects the lane by in_addr_lo: bytes use lane addr_lo; halves use addr_lo[1] and ignore addr_lo[0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes through; any other funct3 yields the full word.
REQ-023 result_src=11 yields WD3=0.
REQ-024 WE3 = valid_q & reg_write_q & (A3!=0) & !stall; writes to x0 are always suppressed.
REQ-025 When stall=1, all registered state holds, WE3=0, and retire_cnt holds.
REQ-026 When flush=1 at an edge, valid_q<=0 regardless of stall or in_valid; flush takes priority over capture.
REQ-027 Retire happens in any cycle with valid_q=1 and stall=0: retire_cnt increments by 1 at the edge, wraps from all-ones to 0, and ignores reg_write.
REQ-028 fwdN_hit = valid_q & reg_write_q & (A3!=0) & (A3==rsN), evaluated combinationally and independent of stall; fwdN_data = WD3 when hit, else 0.
REQ-029 Bypass covers the write-at-posedge and combinational-read window, so decode never sees stale data for a same-cycle write.

Reset
REQ-030 When rst=1 at an edge: valid_q=0, A3=0, WD3=0, reg_write_q=0, retire_cnt=0; so WE3=0 and fwd hits are 0 in the following cycle.
REQ-031 rst has priority over flush, stall, and capture.

Configuration
REQ-032 Macro WB_BYPASS_EN: when defined, REQ-028 is implemented; when undefined, fwd1_hit/fwd2_hit are tied to 0, fwd1_data/fwd2_data are tied to 0, the ports remain present, and decode must stall instead.

Structure
REQ-033 The shared package riscv_pkg holds the result_src encodings, the load funct3 encodings, and the XLEN=32 constant.
REQ-034 Load formatting is a combinational sub-module, load_formatter (inputs: data, funct3, addr_lo; output: 32-bit result).

Verification
REQ-035 Scenario: load 0x80FF_7F01 with LB and addr_lo=3 -> WD3=0xFFFF_FF80 one cycle later; with LBU -> 0x0000_0080; with LH and addr_lo=2 -> 0xFFFF_80FF.
REQ-036 Scenario: ALU result 0x1234 with rd=5 and reg_write=1, stall high for 2 cycles -> WE3 low for 2 cycles, then one WE3 pulse with A3=5; retire_cnt +1 once.
REQ-037 Scenario: rd=0 with reg_write=1 -> WE3=0, fwd hits 0; retire_cnt still increments.
REQ-038 Scenario: rd=7 in the stage, rs1=7, rs2=7 -> both hits 1 with data=WD3; rs1=8 -> fwd1_hit=0, fwd1_data=0; with WB_BYPASS_EN undefined -> all 0.
REQ-039 Scenario: flush and in_valid both high, with stall high -> next cycle valid_q=0, WE3=0, no retire.
REQ-040 Scenario: CNT_W=4, 17 back-to-back retires from reset -> retire_cnt=1; assert rst mid-stream -> retire_cnt=0 and WE3=0 next cycle.
